step_dir_rx: RTL and testbench

//  Receiver for the stepper-drive interface (drv_enable_SM / drv_step / drv_dir) driven by the TR tracking block.

---
 rtl/step_dir_rx.sv | 207 ++++++++++++++++++++
 tb/tb_step_dir_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_rx.sv
`default_nettype none
// ============================================================================
// Module   : step_dir_rx
// Purpose  : Step/direction receiver. Decodes step pulses into a signed
//            position, measures the step period and flags timing violations
//            (direction setup, pulse width, step rate, position limits).
// Ports    : clk, rst (sync, active-low)
//            drv_enable_SM, drv_step, drv_dir  - drive interface inputs
//            pos_load, pos_init                - position preload
//            err_clr                           - clears sticky error flags
//            position, step_stb, step_period, moving
//            err_dir, err_width, err_rate, err_limit (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module step_dir_rx #(
  parameter int POS_W        = 16,
  parameter int PER_W        = 16,
  parameter int POS_MAX      = 2047,
  parameter int POS_MIN      = -2048,
  parameter int MIN_HIGH     = 1,
  parameter int MIN_PERIOD   = 5,
  parameter int DIR_SETUP    = 2,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drv_enable_SM,
  input  logic                    drv_step,
  input  logic                    drv_dir,
  input  logic                    pos_load,
  input  logic signed [POS_W-1:0] pos_init,
  input  logic                    err_clr,
  output logic signed [POS_W-1:0] position,
  output logic                    step_stb,
  output logic [PER_W-1:0]        step_period,
  output logic                    moving,
  output logic                    err_dir,
  output logic                    err_width,
  output logic                    err_rate,
  output logic                    err_limit
);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_ARMED    = 2'd1,
    S_HIGH     = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  localparam logic signed [POS_W-1:0] c_pos_max   = POS_W'(POS_MAX);
  localparam logic signed [POS_W-1:0] c_pos_min   = POS_W'(POS_MIN);
  localparam logic [PER_W-1:0]        c_cnt_max   = '1;
  localparam logic [PER_W-1:0]        c_min_high  = PER_W'(MIN_HIGH);
  localparam logic [PER_W-1:0]        c_min_per   = PER_W'(MIN_PERIOD);
  localparam logic [PER_W-1:0]        c_dir_setup = PER_W'(DIR_SETUP);
  localparam logic [PER_W-1:0]        c_idle      = PER_W'(IDLE_TIMEOUT);

  state_t                   state_q, state_d;
  logic                     step_q, dir_q;
  logic                     first_q, first_d;
  logic [PER_W-1:0]         per_cnt_q, per_cnt_d;
  logic [PER_W-1:0]         dir_cnt_q, dir_cnt_d;
  logic [PER_W-1:0]         hi_cnt_q, hi_cnt_d;
  // A counted rise is applied to the position one cycle later.
  logic                     evt_q, evt_d;
  logic                     evt_dir_q, evt_dir_d;
  logic signed [POS_W-1:0]  position_q, position_d;
  logic                     step_stb_q, step_stb_d;
  logic [PER_W-1:0]         step_period_q, step_period_d;
  logic                     moving_q, moving_d;
  logic                     err_dir_q, err_dir_d;
  logic                     err_width_q, err_width_d;
  logic                     err_rate_q, err_rate_d;
  logic                     err_limit_q, err_limit_d;

  logic                     w_rise, w_fall, w_count;
  logic                     w_set_dir, w_set_width, w_set_rate, w_set_limit;
  logic [PER_W-1:0]         w_per_inc, w_dir_stable;

  always_comb begin
    w_rise  = drv_step & ~step_q;
    w_fall  = ~drv_step & step_q;
    // Only rises seen while armed/in the gap count; a same-cycle load drops it.
    w_count = drv_enable_SM & w_rise & ~pos_load &
              ((state_q == S_ARMED) || (state_q == S_GAP));

    w_per_inc    = (per_cnt_q == c_cnt_max) ? per_cnt_q : per_cnt_q + PER_W'(1);
    // Direction stability including the current cycle; a change restarts at 0.
    w_dir_stable = (drv_dir != dir_q) ? '0 :
                   ((dir_cnt_q == c_cnt_max) ? dir_cnt_q : dir_cnt_q + PER_W'(1));

    // FSM
    state_d = state_q;
    if (!drv_enable_SM) begin
      state_d = S_DISABLED;
    end else begin
      case (state_q)
        S_DISABLED:    if (!drv_step) state_d = S_ARMED;
        S_ARMED, S_GAP: if (w_rise)  state_d = S_HIGH;
        S_HIGH:        if (w_fall)   state_d = S_GAP;
        default:                     state_d = S_DISABLED;
      endcase
    end

    // High-width counter: preloaded with 1 so the rise cycle counts as high.
    hi_cnt_d = PER_W'(1);
    if (state_q == S_HIGH)
      hi_cnt_d = (hi_cnt_q == c_cnt_max) ? hi_cnt_q : hi_cnt_q + PER_W'(1);

    w_set_width = drv_enable_SM & (state_q == S_HIGH) & w_fall & (hi_cnt_q < c_min_high);
    w_set_rate  = w_count & ~first_q & (w_per_inc < c_min_per);
    w_set_dir   = w_count & (w_dir_stable < c_dir_setup);

    per_cnt_d     = w_count ? '0 : w_per_inc;
    dir_cnt_d     = w_dir_stable;
    step_period_d = (w_count & ~first_q) ? w_per_inc : step_period_q;
    first_d       = (state_q == S_DISABLED) ? 1'b1 : (w_count ? 1'b0 : first_q);

    evt_d     = w_count;
    evt_dir_d = drv_dir;

    // Position update from the pending step; a load always wins.
    position_d  = position_q;
    step_stb_d  = 1'b0;
    w_set_limit = 1'b0;
    if (pos_load) begin
      position_d = pos_init;
    end else if (evt_q) begin
      if (evt_dir_q) begin
        if (position_q >= c_pos_max) w_set_limit = 1'b1;
        else begin
          position_d = position_q + POS_W'(1);
          step_stb_d = 1'b1;
        end
      end else begin
        if (position_q <= c_pos_min) w_set_limit = 1'b1;
        else begin
          position_d = position_q - POS_W'(1);
          step_stb_d = 1'b1;
        end
      end
    end

    moving_d = moving_q;
    if (step_stb_d)
      moving_d = 1'b1;
    else if ((state_q == S_DISABLED) || (per_cnt_d >= c_idle))
      moving_d = 1'b0;

    // Sticky flags: a new violation outranks a same-cycle clear.
    err_dir_d   = (err_dir_q   & ~err_clr) | w_set_dir;
    err_width_d = (err_width_q & ~err_clr) | w_set_width;
    err_rate_d  = (err_rate_q  & ~err_clr) | w_set_rate;
    err_limit_d = (err_limit_q & ~err_clr) | w_set_limit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_DISABLED;
      step_q        <= 1'b0;
      dir_q         <= 1'b0;
      first_q       <= 1'b1;
      per_cnt_q     <= '0;
      dir_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      evt_q         <= 1'b0;
      evt_dir_q     <= 1'b0;
      position_q    <= '0;
      step_stb_q    <= 1'b0;
      step_period_q <= '0;
      moving_q      <= 1'b0;
      err_dir_q     <= 1'b0;
      err_width_q   <= 1'b0;
      err_rate_q    <= 1'b0;
      err_limit_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= drv_step;
      dir_q         <= drv_dir;
      first_q       <= first_d;
      per_cnt_q     <= per_cnt_d;
      dir_cnt_q     <= dir_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      evt_q         <= evt_d;
      evt_dir_q     <= evt_dir_d;
      position_q    <= position_d;
      step_stb_q    <= step_stb_d;
      step_period_q <= step_period_d;
      moving_q      <= moving_d;
      err_dir_q     <= err_dir_d;
      err_width_q   <= err_width_d;
      err_rate_q    <= err_rate_d;
      err_limit_q   <= err_limit_d;
    end
  end

  assign position    = position_q;
  assign step_stb    = step_stb_q;
  assign step_period = step_period_q;
  assign moving      = moving_q;
  assign err_dir     = err_dir_q;
  assign err_width   = err_width_q;
  assign err_rate    = err_rate_q;
  assign err_limit   = err_limit_q;

endmodule
`default_nettype wire

// File: tb/tb_step_dir_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_dir_rx
// Purpose  : Self-checking bench for step_dir_rx. A cycle-stamp reference
//            model (times of last rise, last direction change, pending step)
//            predicts every output after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_dir_rx;

  localparam int MIN_HIGH     = 1;
  localparam int MIN_PERIOD   = 5;
  localparam int DIR_SETUP    = 2;
  localparam int IDLE_TIMEOUT = 1000;
  localparam int POS_MAX      = 2047;
  localparam int POS_MIN      = -2048;

  logic               clk = 1'b0;
  logic               rst, drv_enable_SM, drv_step, drv_dir, pos_load, err_clr;
  logic signed [15:0] pos_init;
  logic signed [15:0] position;
  logic               step_stb, moving, err_dir, err_width, err_rate, err_limit;
  logic [15:0]        step_period;

  int n_pass = 0, n_fail = 0, n_total = 0, stb_seen = 0;

  step_dir_rx dut (
    .clk(clk), .rst(rst), .drv_enable_SM(drv_enable_SM), .drv_step(drv_step),
    .drv_dir(drv_dir), .pos_load(pos_load), .pos_init(pos_init), .err_clr(err_clr),
    .position(position), .step_stb(step_stb), .step_period(step_period),
    .moving(moving), .err_dir(err_dir), .err_width(err_width),
    .err_rate(err_rate), .err_limit(err_limit)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  longint             cyc = 0;
  bit                 m_prev_step, m_prev_dir, m_live, m_high, m_has_prev, m_pend, m_pend_dir;
  longint             m_last_rise, m_dir_chg, m_hi_start;
  logic signed [15:0] m_pos;
  logic [15:0]        m_period;
  bit                 m_stb, m_moving, m_edir, m_ewid, m_erate, m_elim;

  function automatic void model_edge();
    bit rise, fall, counted, sd, sw, sr, sl;
    longint gap, stable;
    cyc++;
    if (!rst) begin
      m_prev_step = 0; m_prev_dir = 0; m_live = 0; m_high = 0; m_has_prev = 0;
      m_pend = 0; m_pend_dir = 0; m_last_rise = cyc; m_dir_chg = cyc; m_hi_start = cyc;
      m_pos = 0; m_period = 0; m_stb = 0; m_moving = 0;
      m_edir = 0; m_ewid = 0; m_erate = 0; m_elim = 0;
      return;
    end
    sd = 0; sw = 0; sr = 0; sl = 0;
    rise = drv_step && !m_prev_step;
    fall = !drv_step && m_prev_step;
    if (drv_dir != m_prev_dir) m_dir_chg = cyc;
    stable  = cyc - m_dir_chg;
    counted = m_live && drv_enable_SM && rise && !pos_load;

    if (m_high && drv_enable_SM && fall) begin
      if (cyc - m_hi_start < MIN_HIGH) sw = 1;
      m_high = 0;
    end
    if (!drv_enable_SM) m_high = 0;
    if (m_live && drv_enable_SM && rise) begin
      m_high = 1;
      m_hi_start = cyc;
    end

    m_stb = 0;
    if (pos_load) m_pos = pos_init;
    else if (m_pend) begin
      if (m_pend_dir) begin
        if (m_pos >= POS_MAX) sl = 1; else begin m_pos = m_pos + 1; m_stb = 1; end
      end else begin
        if (m_pos <= POS_MIN) sl = 1; else begin m_pos = m_pos - 1; m_stb = 1; end
      end
    end
    m_pend     = counted;
    m_pend_dir = drv_dir;

    if (counted) begin
      gap = cyc - m_last_rise;
      if (m_has_prev) begin
        m_period = (gap > 65535) ? 16'hFFFF : 16'(gap);
        if (gap < MIN_PERIOD) sr = 1;
      end
      if (stable < DIR_SETUP) sd = 1;
      m_last_rise = cyc;
      m_has_prev  = 1;
    end
    if (!drv_enable_SM) m_has_prev = 0;

    if (m_stb) m_moving = 1;
    else if (!m_live || (cyc - m_last_rise) >= IDLE_TIMEOUT) m_moving = 0;

    m_live = drv_enable_SM && (m_live || !drv_step);
    m_edir  = (m_edir  && !err_clr) || sd;
    m_ewid  = (m_ewid  && !err_clr) || sw;
    m_erate = (m_erate && !err_clr) || sr;
    m_elim  = (m_elim  && !err_clr) || sl;
    m_prev_step = drv_step;
    m_prev_dir  = drv_dir;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d (cycle %0d)", tag, $signed(obs), $signed(exp), cyc);
    end
  endtask

  task automatic compare_all();
    chk("position",    position,    m_pos);
    chk("step_stb",    step_stb,    m_stb);
    chk("step_period", step_period, m_period);
    chk("moving",      moving,      m_moving);
    chk("err_dir",     err_dir,     m_edir);
    chk("err_width",   err_width,   m_ewid);
    chk("err_rate",    err_rate,    m_erate);
    chk("err_limit",   err_limit,   m_elim);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (step_stb === 1'b1) stb_seen++;
  endtask

  // One high phase then one low phase; load/clear strobes last one cycle.
  task automatic pulse(input int hi, input int lo);
    drv_step = 1'b1;
    tick();
    pos_load = 1'b0;
    err_clr  = 1'b0;
    repeat (hi - 1) tick();
    drv_step = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic load(input int val);
    pos_load = 1'b1;
    pos_init = 16'(val);
    tick();
    pos_load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; drv_enable_SM = 1'b1; drv_step = 1'b0; drv_dir = 1'b1;
    pos_load = 1'b0; pos_init = '0; err_clr = 1'b0;

    // 1: reset, then ten 1-high/4-low up steps
    repeat (3) tick();
    chk("rst_position", position, 0);
    chk("rst_period", step_period, 0);
    chk("rst_moving", moving, 0);
    chk("rst_errs", {err_dir, err_width, err_rate, err_limit, step_stb}, 0);
    rst = 1'b1;
    repeat (3) tick();
    stb_seen = 0;
    repeat (10) pulse(1, 4);
    chk("t1_position", position, 10);
    chk("t1_stb_count", stb_seen, 10);
    chk("t1_period", step_period, 5);
    chk("t1_errs", {err_dir, err_width, err_rate, err_limit}, 0);
    chk("t1_moving", moving, 1);

    // 2: down steps at period 3
    drv_dir = 1'b0;
    load(0);
    repeat (5) tick();
    pulse(1, 2);
    chk("t2_rate_after_first", err_rate, 0);
    drv_step = 1'b1;
    tick();
    chk("t2_rate_after_second", err_rate, 1);
    drv_step = 1'b0;
    repeat (2) tick();
    pulse(1, 2);
    chk("t2_position", position, -3);
    chk("t2_period", step_period, 3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t2_rate_cleared", err_rate, 0);

    // 3: upper limit
    drv_dir = 1'b1;
    load(2046);
    repeat (4) tick();
    stb_seen = 0;
    repeat (3) pulse(1, 5);
    chk("t3_position", position, 2047);
    chk("t3_stb_count", stb_seen, 1);
    chk("t3_err_limit", err_limit, 1);

    // load and rise in the same cycle: load wins, no step
    stb_seen = 0;
    pos_load = 1'b1; pos_init = 16'sd100; drv_step = 1'b1;
    tick();
    pos_load = 1'b0; drv_step = 1'b0;
    repeat (5) tick();
    chk("load_wins_position", position, 100);
    chk("load_wins_stb", stb_seen, 0);

    // limit violation in the same cycle as err_clr: flag stays set
    load(2047);
    repeat (5) tick();
    err_clr = 1'b1; drv_step = 1'b1;
    tick();
    drv_step = 1'b0;
    tick();
    err_clr = 1'b0;
    tick();
    chk("set_beats_clear", err_limit, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("limit_cleared", err_limit, 0);

    // 4: direction change in the rise cycle
    load(0);
    repeat (5) tick();
    drv_dir = 1'b0; drv_step = 1'b1;
    tick();
    drv_step = 1'b0;
    repeat (5) tick();
    chk("t4_err_dir", err_dir, 1);
    chk("t4_position", position, -1);

    // 5: enable drop while high, re-enable while still high
    drv_dir = 1'b1;
    load(0);
    repeat (5) tick();
    drv_step = 1'b1;
    tick();
    drv_enable_SM = 1'b0;
    tick();
    drv_enable_SM = 1'b1;
    repeat (3) tick();
    drv_step = 1'b0;
    repeat (4) tick();
    chk("t5_held_high_ignored", position, 1);
    pulse(1, 5);
    chk("t5_next_rise_counted", position, 2);

    // 6: idle timeout, then reset in the middle of a pulse
    repeat (5) tick();
    drv_step = 1'b1;
    tick();
    drv_step = 1'b0;
    repeat (999) tick();
    chk("t6_moving_before_timeout", moving, 1);
    tick();
    chk("t6_moving_at_timeout", moving, 0);
    drv_step = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t6_rst_position", position, 0);
    chk("t6_rst_outputs", {step_stb, moving, err_dir, err_width, err_rate, err_limit}, 0);
    chk("t6_rst_period", step_period, 0);
    rst = 1'b1;
    repeat (3) tick();
    drv_step = 1'b0;
    repeat (4) tick();
    pulse(1, 4);
    chk("t6_after_reset_position", position, 1);

    // randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      drv_dir       = 1'($urandom_range(1));
      drv_enable_SM = ($urandom_range(7) != 0);
      err_clr       = ($urandom_range(5) == 0);
      pos_load      = ($urandom_range(9) == 0);
      case ($urandom_range(3))
        0:       pos_init = 16'sd2046;
        1:       pos_init = -16'sd2047;
        2:       pos_init = 16'sd0;
        default: pos_init = 16'(int'($urandom_range(4095)) - 2048);
      endcase
      pulse(int'($urandom_range(3, 1)), int'($urandom_range(7, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
